// File: rtl/dm_bhw_if.sv
// Request/response bundle for the dm_bhw byte/halfword/word data memory.
// The master issues load/store requests; the slave returns ready, load data and fault.
interface dm_bhw_if #(
    parameter int ADDR_W = 14
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sext;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       din;
    logic              ready;
    logic              rvalid;
    logic [31:0]       dout;
    logic              fault;

    modport master (
        output req, we, size, sext, addr, din,
        input  ready, rvalid, dout, fault
    );

    modport slave (
        input  req, we, size, sext, addr, din,
        output ready, rvalid, dout, fault
    );
endinterface

// File: rtl/dm_bhw.sv
// Little-endian data memory with byte/halfword/word access, one-cycle load latency,
// fault reporting for illegal requests and a zeroing sweep after every reset.
module dm_bhw #(
    parameter int DEPTH  = 12288,
    parameter int ADDR_W = 14
) (
    input  logic     clk,
    input  logic     rst_n,
    dm_bhw_if.slave  bus
);
    localparam int WORDS = DEPTH / 4;
    localparam int PTR_W = ADDR_W - 2;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic [31:0]        mem [WORDS];

    logic               accept;
    logic               valid;
    logic [ADDR_W:0]    span;
    logic [ADDR_W:0]    last;
    logic               bad_size;
    logic               misalign;
    logic [1:0]         lane;
    logic [4:0]         shamt;
    logic [PTR_W-1:0]   widx;
    logic [3:0]         be;
    logic [31:0]        wdata;
    logic [31:0]        rshift;
    logic               rvalid_q;
    logic               fault_q;
    logic [31:0]        dout_q;

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                             input logic sx);
        case (sz)
            2'b00:   return sx ? {{24{w[7]}}, w[7:0]}   : {24'b0, w[7:0]};
            2'b01:   return sx ? {{16{w[15]}}, w[15:0]} : {16'b0, w[15:0]};
            default: return w;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            CLEAR: begin
                if (ptr == PTR_W'(WORDS - 1)) begin
                    state_nxt = IDLE;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.ready = (state == IDLE);
    assign accept    = bus.req && bus.ready;

    // Request decode; the end-of-access address carries one extra bit so it never wraps.
    always_comb begin
        span     = '0;
        bad_size = 1'b0;
        be       = 4'b0000;
        lane     = bus.addr[1:0];
        case (bus.size)
            2'b00:   begin span = (ADDR_W+1)'(0); be = 4'b0001 << lane; end
            2'b01:   begin span = (ADDR_W+1)'(1); be = 4'b0011 << lane; end
            2'b10:   begin span = (ADDR_W+1)'(3); be = 4'b1111;         end
            default: bad_size = 1'b1;
        endcase
        misalign = ((bus.size == 2'b01) && bus.addr[0]) ||
                   ((bus.size == 2'b10) && (bus.addr[1:0] != 2'b00));
        last     = {1'b0, bus.addr} + span;
        valid    = !bad_size && !misalign && (last < (ADDR_W+1)'(DEPTH));
    end

    assign shamt  = {lane, 3'b000};
    assign widx   = bus.addr[ADDR_W-1:2];
    assign wdata  = bus.din << shamt;
    assign rshift = mem[widx] >> shamt;

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[ptr] <= '0;
        end else if (accept && bus.we && valid) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Response stage: load data and status appear the cycle after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            fault_q  <= 1'b0;
            dout_q   <= '0;
        end else begin
            rvalid_q <= accept && !bus.we && valid;
            fault_q  <= accept && !valid;
            if (accept && !bus.we && valid) dout_q <= load_ext(rshift, bus.size, bus.sext);
        end
    end

    assign bus.rvalid = rvalid_q;
    assign bus.fault  = fault_q;
    assign bus.dout   = dout_q;
endmodule

// File: tb/tb_dm_bhw.sv
// Directed self-checking bench for dm_bhw: reset sweep, little-endian access,
// extension, back-to-back forwarding, fault cases and reset during activity.
module tb_dm_bhw;
    localparam int DEPTH  = 12288;
    localparam int ADDR_W = 14;
    localparam int WORDS  = DEPTH / 4;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    int   cyc;

    dm_bhw_if #(.ADDR_W(ADDR_W)) bus();

    dm_bhw #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic w, input logic [1:0] s, input logic x,
                        input logic [ADDR_W-1:0] a, input logic [31:0] d);
        bus.req  = 1'b1;
        bus.we   = w;
        bus.size = s;
        bus.sext = x;
        bus.addr = a;
        bus.din  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (bus.ready !== 1'b1 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic load_chk(input string tag, input logic [1:0] s, input logic x,
                            input logic [ADDR_W-1:0] a, input logic [31:0] exp);
        xfer(1'b0, s, x, a, 32'h0);
        chk({tag, "_rvalid"}, {31'b0, bus.rvalid}, 32'h1);
        chk(tag, bus.dout, exp);
    endtask

    task automatic fault_chk(input string tag, input logic w, input logic [1:0] s,
                             input logic [ADDR_W-1:0] a, input logic [31:0] d,
                             input logic [31:0] dout_exp);
        xfer(w, s, 1'b0, a, d);
        chk({tag, "_fault"}, {31'b0, bus.fault}, 32'h1);
        chk({tag, "_rvalid"}, {31'b0, bus.rvalid}, 32'h0);
        chk({tag, "_dout"}, bus.dout, dout_exp);
        idle();
        chk({tag, "_pulse"}, {31'b0, bus.fault}, 32'h0);
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        bus.req  = 1'b0;
        bus.we   = 1'b0;
        bus.size = 2'b00;
        bus.sext = 1'b0;
        bus.addr = '0;
        bus.din  = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, bus.ready}, 32'h0);
        chk("rst_rvalid", {31'b0, bus.rvalid}, 32'h0);
        chk("rst_fault", {31'b0, bus.fault}, 32'h0);
        chk("rst_dout", bus.dout, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(cyc);
        chk("clear_cycles", cyc, WORDS);

        load_chk("zero_w0", 2'b10, 1'b0, 14'h0000, 32'h0);
        load_chk("zero_w4", 2'b10, 1'b0, 14'h0004, 32'h0);
        load_chk("zero_top", 2'b10, 1'b0, 14'(DEPTH - 4), 32'h0);
        load_chk("zero_lastb", 2'b00, 1'b1, 14'(DEPTH - 1), 32'h0);

        xfer(1'b1, 2'b10, 1'b0, 14'h0010, 32'h8765A1F2);
        chk("st_w_rvalid", {31'b0, bus.rvalid}, 32'h0);
        chk("st_w_fault", {31'b0, bus.fault}, 32'h0);
        load_chk("lb_10_s", 2'b00, 1'b1, 14'h0010, 32'hFFFFFFF2);
        load_chk("lh_12_z", 2'b01, 1'b0, 14'h0012, 32'h00008765);
        load_chk("lb_11_s", 2'b00, 1'b1, 14'h0011, 32'hFFFFFFA1);
        load_chk("lh_12_s", 2'b01, 1'b1, 14'h0012, 32'hFFFF8765);
        load_chk("lb_10_z", 2'b00, 1'b0, 14'h0010, 32'h000000F2);

        // Store followed immediately by a load of the same word.
        xfer(1'b1, 2'b00, 1'b0, 14'h0011, 32'h000000AB);
        chk("b2b_st_rvalid", {31'b0, bus.rvalid}, 32'h0);
        load_chk("b2b_lw_10", 2'b10, 1'b0, 14'h0010, 32'h8765ABF2);
        idle();
        chk("rvalid_pulse", {31'b0, bus.rvalid}, 32'h0);
        chk("dout_hold", bus.dout, 32'h8765ABF2);

        xfer(1'b1, 2'b01, 1'b0, 14'h0020, 32'hCDCD1234);
        xfer(1'b1, 2'b01, 1'b0, 14'h0022, 32'hFFFFBEEF);
        load_chk("sh_lanes", 2'b10, 1'b0, 14'h0020, 32'hBEEF1234);
        load_chk("prev_word", 2'b10, 1'b0, 14'h0010, 32'h8765ABF2);
        idle();

        fault_chk("f_sw_13", 1'b1, 2'b10, 14'h0013, 32'h11111111, 32'h8765ABF2);
        fault_chk("f_lh_21", 1'b0, 2'b01, 14'h0021, 32'h0, 32'h8765ABF2);
        fault_chk("f_ld_sz3", 1'b0, 2'b11, 14'h0010, 32'h0, 32'h8765ABF2);
        fault_chk("f_st_sz3", 1'b1, 2'b11, 14'h0010, 32'h22222222, 32'h8765ABF2);
        fault_chk("f_sw_top", 1'b1, 2'b10, 14'(DEPTH - 2), 32'h33333333, 32'h8765ABF2);
        fault_chk("f_lb_depth", 1'b0, 2'b00, 14'(DEPTH), 32'h0, 32'h8765ABF2);
        load_chk("mem_kept_10", 2'b10, 1'b0, 14'h0010, 32'h8765ABF2);
        load_chk("mem_kept_20", 2'b10, 1'b0, 14'h0020, 32'hBEEF1234);
        load_chk("mem_kept_top", 2'b10, 1'b0, 14'(DEPTH - 4), 32'h0);

        // Reset pulse part-way through the sweep; requests while not ready are ignored.
        idle();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.req  = 1'b1;
        bus.we   = 1'b1;
        bus.size = 2'b11;
        bus.addr = 14'h0013;
        repeat (100) @(posedge clk);
        #1;
        chk("mid_ready", {31'b0, bus.ready}, 32'h0);
        chk("mid_nofault", {31'b0, bus.fault}, 32'h0);
        chk("mid_norvalid", {31'b0, bus.rvalid}, 32'h0);
        bus.req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(cyc);
        chk("restart_cycles", cyc, WORDS);
        load_chk("recleared_10", 2'b10, 1'b0, 14'h0010, 32'h0);

        // Reset right after a load is accepted drops its response.
        xfer(1'b1, 2'b10, 1'b0, 14'h0010, 32'h11223344);
        xfer(1'b0, 2'b10, 1'b0, 14'h0010, 32'h0);
        rst_n   = 1'b0;
        bus.req = 1'b0;
        #1;
        chk("drop_rvalid", {31'b0, bus.rvalid}, 32'h0);
        chk("drop_dout", bus.dout, 32'h0);
        @(posedge clk);
        #1;
        chk("drop_rvalid2", {31'b0, bus.rvalid}, 32'h0);
        chk("drop_fault", {31'b0, bus.fault}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(cyc);
        chk("final_clear", cyc, WORDS);
        load_chk("final_10", 2'b10, 1'b0, 14'h0010, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dm_bhw.md
DM_BHW -- requirements
Module: dm_bhw

Interface
REQ-001 SHALL have parameter DEPTH, default 12288, memory size in bytes; multiple of 4.
REQ-002 SHALL have parameter ADDR_W, default 14, byte-address width; 2**ADDR_W >= DEPTH.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port req  input  1  access request, sampled on clk.
REQ-006 SHALL have port we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 SHALL have port sext  input  1  load extension: 1 sign-extend, 0 zero-extend; ignored for word loads and stores.
REQ-009 SHALL have port addr  input  ADDR_W  byte address.
REQ-010 SHALL have port din  input  32  store data, right-justified; low byte = din[7:0].
REQ-011 SHALL have port ready  output  1  block accepts a request this cycle.
REQ-012 SHALL have port rvalid  output  1  dout holds load result; one-cycle pulse.
REQ-013 SHALL have port dout  output  32  registered load data.
REQ-014 SHALL have port fault  output  1  one-cycle pulse; previous accepted request was rejected.

Function
REQ-015 SHALL have two states: CLEAR and IDLE; ready = 1 only in IDLE.
REQ-016 In CLEAR: one aligned 32-bit word per cycle written to zero, from byte 0 upward via an internal word pointer; IDLE entered on the cycle after word DEPTH/4-1 is cleared, so CLEAR lasts exactly DEPTH/4 cycles after rst_n release.
REQ-017 Accept = req && ready at a rising edge; req while ready = 0 ignored, no side effects, no fault.
REQ-018 Storage little-endian: byte at addr+k occupies bits [8k+7:8k] of the value.
REQ-019 Accepted store, valid: byte writes din[7:0] to addr; halfword writes din[15:0] to addr..addr+1; word writes din[31:0] to addr..addr+3; all other bytes unchanged; rvalid stays 0.
REQ-020 Accepted load, valid: dout updated and rvalid = 1 in the following cycle (latency 1); byte/halfword results extended to 32 bits per sext.
REQ-021 Invalid request: size = 11; halfword with addr[0] = 1; word with addr[1:0] != 00; or last byte touched (addr + bytes - 1) >= DEPTH.
REQ-022 Invalid request SHALL NOT modify memory or dout; fault = 1 and rvalid = 0 in the following cycle.
REQ-023 Back-to-back accepts every cycle SHALL be supported; a load in the cycle after a store to the same bytes returns the stored data.
REQ-024 dout holds its last value when rvalid = 0.
REQ-025 Address arithmetic SHALL be evaluated at ADDR_W+1 bits so the range check does not wrap at the top of the address space.

Reset
REQ-026 rst_n low asynchronously forces state = CLEAR, word pointer = 0, ready = 0, rvalid = 0, fault = 0, dout = 0.
REQ-027 Memory contents are not reset asynchronously; they are zeroed only by the CLEAR sweep after rst_n goes high.
REQ-028 rst_n asserted mid-CLEAR restarts the sweep at word 0; rst_n asserted mid-access drops that access, and no rvalid or fault pulse follows it.

Verification
REQ-029 Release rst_n -> ready = 0 for exactly DEPTH/4 cycles (3072 at default), then 1; word loads at 0, 4 and DEPTH-4 return 0x00000000.
REQ-030 Word store 0x8765A1F2 to addr 0x10, then byte load at 0x10 with sext = 1 -> 0xFFFFFFF2; halfword load at 0x12 with sext = 0 -> 0x00008765; byte load at 0x11 with sext = 1 -> 0xFFFFFFA1.
REQ-031 Byte store 0xAB to addr 0x11, then word load at 0x10 -> 0x8765ABF2; the load is issued the cycle after the store and rvalid asserts exactly one cycle after the load is accepted.
REQ-032 Word store at addr 0x13; halfword load at addr 0x21; any access with size = 11; word store at DEPTH-2 -> fault pulses once per request, rvalid = 0, memory and dout unchanged.
REQ-033 Assert rst_n low for 1 cycle at cycle 100 of CLEAR -> sweep restarts and ready rises DEPTH/4 cycles after release; rst_n low the cycle after a load accept -> no rvalid, dout = 0.
